// File: rtl/rptr_empty.sv
// Read-side pointer, empty flag and occupancy tracker for a dual-clock FIFO.
// All state lives in the read clock domain; rq2_wptr_i must already be synchronized.
module rptr_empty #(
  parameter int unsigned AddrLines         = 8,
  parameter int unsigned AlmostEmptyThresh = 4
) (
  input  logic                 rclk_i,
  input  logic                 rrst_ni,
  input  logic                 rinc_i,
  input  logic [AddrLines:0]   rq2_wptr_i,
  output logic [AddrLines-1:0] raddr_o,
  output logic [AddrLines:0]   rptr_o,
  output logic                 rempty_o,
  output logic                 almost_empty_o,
  output logic [AddrLines:0]   rlevel_o,
  output logic                 underflow_o
);

  localparam int unsigned      PtrW   = AddrLines + 1;
  localparam logic [PtrW-1:0]  Thresh = PtrW'(AlmostEmptyThresh);

  logic [PtrW-1:0] rbin_q, rbin_d;
  logic [PtrW-1:0] rgray_q, rgray_d;
  logic [PtrW-1:0] rlevel_q, rlevel_d;
  logic [PtrW-1:0] wbin_sync;
  logic            rempty_q, rempty_d;
  logic            almost_empty_q, almost_empty_d;
  logic            underflow_q, underflow_d;
  logic            rd_accept;

  // Gray-to-binary: bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    wbin_sync = '0;
    for (int i = 0; i < int'(PtrW); i++) begin
      wbin_sync[i] = ^(rq2_wptr_i >> i);
    end
  end

  always_comb begin
    rd_accept      = rinc_i & ~rempty_q;
    rbin_d         = rbin_q + {{AddrLines{1'b0}}, rd_accept};
    rgray_d        = (rbin_d >> 1) ^ rbin_d;
    // Full-width compare: the wrap bit distinguishes empty from full.
    rempty_d       = (rgray_d == rq2_wptr_i);
    // Modular subtraction stays correct across the pointer wrap.
    rlevel_d       = wbin_sync - rbin_d;
    almost_empty_d = (rlevel_d <= Thresh);
    underflow_d    = underflow_q | (rinc_i & rempty_q);
  end

  always_ff @(posedge rclk_i or negedge rrst_ni) begin
    if (!rrst_ni) begin
      rbin_q         <= '0;
      rgray_q        <= '0;
      rlevel_q       <= '0;
      rempty_q       <= 1'b1;
      almost_empty_q <= 1'b1;
      underflow_q    <= 1'b0;
    end else begin
      rbin_q         <= rbin_d;
      rgray_q        <= rgray_d;
      rlevel_q       <= rlevel_d;
      rempty_q       <= rempty_d;
      almost_empty_q <= almost_empty_d;
      underflow_q    <= underflow_d;
    end
  end

  assign raddr_o        = rbin_q[AddrLines-1:0];
  assign rptr_o         = rgray_q;
  assign rempty_o       = rempty_q;
  assign almost_empty_o = almost_empty_q;
  assign rlevel_o       = rlevel_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_rptr_empty.sv
// Bench for rptr_empty: directed steps and random traffic checked against
// an occupancy model built from plain read/write counts.
module tb_rptr_empty;

  logic       clk = 1'b0;
  logic       rrst_n = 1'b0;
  logic       rinc = 1'b0;
  logic [8:0] rq2_wptr = '0;
  logic [7:0] raddr;
  logic [8:0] rptr;
  logic       rempty;
  logic       almost_empty;
  logic [8:0] rlevel;
  logic       underflow;

  int total = 0;
  int bad   = 0;

  // Model: total entries written (w) and total entries read (reads).
  int m_w = 0;
  int m_reads = 0;
  bit m_empty = 1'b1;
  bit m_under = 1'b0;

  rptr_empty #(
    .AddrLines        (8),
    .AlmostEmptyThresh(4)
  ) dut (
    .rclk_i        (clk),
    .rrst_ni       (rrst_n),
    .rinc_i        (rinc),
    .rq2_wptr_i    (rq2_wptr),
    .raddr_o       (raddr),
    .rptr_o        (rptr),
    .rempty_o      (rempty),
    .almost_empty_o(almost_empty),
    .rlevel_o      (rlevel),
    .underflow_o   (underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] gray(input int v);
    logic [8:0] b;
    b = 9'(v % 512);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int lvl;
    lvl = m_w - m_reads;
    check({tag, ":raddr"}, 32'(raddr), 32'(m_reads % 256));
    check({tag, ":rptr"}, 32'(rptr), 32'(gray(m_reads)));
    check({tag, ":rempty"}, 32'(rempty), 32'(m_empty));
    check({tag, ":rlevel"}, 32'(rlevel), 32'(m_empty ? 0 : lvl));
    check({tag, ":almost_empty"}, 32'(almost_empty), 32'((m_empty ? 0 : lvl) <= 4));
    check({tag, ":underflow"}, 32'(underflow), 32'(m_under));
  endtask

  // Drive one cycle: read request and synchronized write count, then check after the edge.
  task automatic step(input bit rd, input int w_new, input string tag);
    rinc     = rd;
    rq2_wptr = gray(w_new);
    @(posedge clk);
    if (rd && m_empty) m_under = 1'b1;
    if (rd && !m_empty) m_reads++;
    m_w     = w_new;
    m_empty = (m_w == m_reads);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rrst_n   = 1'b0;
    rinc     = 1'($urandom_range(0, 1));
    rq2_wptr = 9'($urandom);
    m_w = 0; m_reads = 0; m_empty = 1'b1; m_under = 1'b0;
    #1;
    check_all("async_reset");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      rinc     = 1'($urandom_range(0, 1));
      rq2_wptr = 9'($urandom);
      #1;
      check_all("hold_reset");
    end
    rinc     = 1'b0;
    rq2_wptr = '0;
    #1;
    rrst_n = 1'b1;
    step(1'b0, 0, "post_reset");
  endtask

  initial begin
    int w;
    @(posedge clk);
    #1;
    do_reset();

    // Single entry arrives, then is read.
    step(1'b0, 1, "single_arrive");
    step(1'b1, 1, "single_read");
    check("single_rptr_lit", 32'(rptr), 32'h001);
    check("single_raddr_lit", 32'(raddr), 32'h1);

    // Reads while empty are dropped and set the sticky flag.
    step(1'b1, 1, "underflow_1");
    step(1'b1, 1, "underflow_2");
    check("underflow_lit", 32'(underflow), 32'h1);
    step(1'b0, 2, "uf_refill");
    step(1'b1, 2, "uf_valid_read");
    step(1'b0, 2, "uf_idle");
    do_reset();

    // Almost-empty threshold crossing.
    step(1'b0, 5, "ae_fill5");
    check("ae_rlevel5_lit", 32'(rlevel), 32'd5);
    step(1'b1, 5, "ae_read_to4");
    check("ae_flag_lit", 32'(almost_empty), 32'h1);
    do_reset();

    // Full occupancy.
    step(1'b0, 256, "full");
    check("full_rlevel_lit", 32'(rlevel), 32'd256);
    step(1'b1, 256, "full_read");
    do_reset();

    // Wrap-around with the writer kept 3 entries ahead.
    step(1'b0, 3, "wrap_prime");
    for (int i = 0; i < 600; i++) begin
      step(1'b1, m_reads + 4, "wrap");
    end

    // Random traffic: alternate fill-biased and drain-biased phases.
    do_reset();
    w = 0;
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 400; i++) begin
        int wr_pct;
        int rd_pct;
        wr_pct = (ph % 2 == 0) ? 85 : 25;
        rd_pct = (ph % 2 == 0) ? 30 : 80;
        if ($urandom_range(0, 99) < wr_pct) w += $urandom_range(1, 2);
        if (w - m_reads > 256) w = m_reads + 256;
        step(($urandom_range(0, 99) < rd_pct), w, "random");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rptr_empty.md
# rptr_empty

Read-side pointer and empty-flag generator for the dual-clock FIFO. It is the counterpart of the write-pointer/full block and lives entirely in the read clock domain. It advances a binary read pointer on accepted reads, exports its Gray-coded form for synchronization into the write domain, and compares that form against the 2-flop-synchronized write pointer to produce a registered empty flag. It also derives a registered occupancy count, an almost-empty flag and a sticky underflow flag for the read-side consumer.

## Interface
- ADDR_LINES, 8, address width; FIFO depth = 2^ADDR_LINES (256).
- ALMOST_EMPTY_THRESH, 4, almost_empty asserts when occupancy <= this value (0..2^ADDR_LINES).

- rclk  input  1  read-domain clock; all state updates on its rising edge.
- rrst  input  1  reset, asynchronous, active-low; one clock domain only.
- rinc  input  1  read request; accepted only when rempty is 0.
- rq2_wptr  input  ADDR_LINES+1  Gray write pointer, already 2-flop synchronized into rclk.
- raddr  output  ADDR_LINES  RAM read address = rbin[ADDR_LINES-1:0], combinational from the register.
- rptr  output  ADDR_LINES+1  registered Gray read pointer, sent to the write-domain synchronizer.
- rempty  output  1  registered empty flag.
- almost_empty  output  1  registered; occupancy <= ALMOST_EMPTY_THRESH.
- rlevel  output  ADDR_LINES+1  registered occupancy as seen from the read side, 0..2^ADDR_LINES.
- underflow  output  1  sticky; set by any read attempt while empty.

## Operation
- Internal binary pointer rbin holds ADDR_LINES+1 bits. The MSB is the wrap bit.
- rbinnext = rbin + (rinc & ~rempty), modulo 2^(ADDR_LINES+1).
- rgraynext = (rbinnext >> 1) ^ rbinnext.
- rempty_val = (rgraynext == rq2_wptr), a full-width compare including the MSB.
- wbin_sync = Gray-to-binary of rq2_wptr. Bit i is the XOR of rq2_wptr[ADDR_LINES:i]. This is combinational.
- level_next = wbin_sync - rbinnext, modulo 2^(ADDR_LINES+1). It ranges 0..2^ADDR_LINES.
- almost_empty_val = (level_next <= ALMOST_EMPTY_THRESH).
- Registered on each rclk edge: {rbin, rptr} <= {rbinnext, rgraynext}; rempty <= rempty_val; rlevel <= level_next; almost_empty <= almost_empty_val.
- underflow <= underflow | (rinc & rempty). It is cleared only by reset.
- A read while empty is dropped: the pointer holds, raddr does not change, and underflow sets.
- The pointer wraps from 2^(ADDR_LINES+1)-1 to 0 without any special handling. The Gray sequence stays single-bit-change across the wrap.
- No FSM is used. Behaviour is fully defined by the pointer, flag and count registers.

## Timing
- Reset (rrst low, asynchronous) forces: rbin=0, rptr=0, rempty=1, almost_empty=1, rlevel=0, underflow=0, and therefore raddr=0.
- The first edge after rrst releases evaluates normally.
- Read latency: when rinc=1 and rempty=0 at edge N, raddr and rptr reflect the incremented pointer after edge N.
- rempty assertion is immediate. If the accepted read empties the FIFO, rempty=1 after that same edge N.
- rempty deassertion is pessimistic. It falls one rclk after rq2_wptr changes, which is three rclk edges after wptr changes in the write domain, counting the synchronizer.
- Simultaneous read and write-pointer change in one cycle: both are folded into level_next and rempty_val at the same edge, with no priority conflict.
- rlevel and almost_empty may under-report occupancy by the synchronizer delay. They never over-report.

## Test plan
- Reset values: hold rrst=0 with random rinc and rq2_wptr → rempty=1, almost_empty=1, rlevel=0, rptr=0, raddr=0, underflow=0. Release reset with rq2_wptr=0 → all outputs unchanged.
- Single entry: drive rq2_wptr=9'h001 (Gray of 1) → after the next edge rempty=0, rlevel=1, almost_empty=1. Pulse rinc for one cycle → after that edge raddr=1, rptr=9'h001, rempty=1, rlevel=0.
- Underflow: with rempty=1, assert rinc for 2 cycles → rptr is unchanged, underflow=1 and stays 1. Subsequent valid reads do not clear underflow; only rrst=0 does.
- Almost-empty boundary: rq2_wptr=Gray(5)=9'h007 with rbin=0 → rlevel=5, almost_empty=0. One read → rlevel=4, almost_empty=1.
- Full occupancy: rq2_wptr=Gray(256)=9'h180 with rbin=0 → rempty=0, rlevel=256, almost_empty=0.
- Wrap-around: stream 600 reads with rq2_wptr kept 3 entries ahead → rptr passes 9'h100 (Gray of 511) to 9'h000. rempty stays 0, and rlevel equals 3 after every edge.
